slice_swap_skid: RTL

//   Registered ready/valid stage feeding the 16-bit byte-swapped register sink path.

---
 rtl/slice_swap_pkg.sv | 31 +++
 rtl/slice_swap_lane_rev.sv | 22 ++
 rtl/slice_swap_skid.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/slice_swap_pkg.sv
// Shared types and helpers for the byte-swapping skid stage feeding the width16 sink.
// The optional parity feature is enabled by defining SLICE_SWAP_PARITY_EN.
package slice_swap_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int LANE_DEFAULT  = 8;
    localparam int WIDTH_DEFAULT = 16;
    localparam int LANES_DEFAULT = WIDTH_DEFAULT / LANE_DEFAULT;

    // Reference lane reversal for the default 16-bit word; the RTL uses the parameterised sub-module.
    function automatic logic [WIDTH_DEFAULT-1:0] lane_rev(
        input logic [WIDTH_DEFAULT-1:0] data,
        input logic                     swap
    );
        logic [WIDTH_DEFAULT-1:0] result;
        result = data;
        if (swap) begin
            for (int i = 0; i < LANES_DEFAULT; i++) begin
                result[i*LANE_DEFAULT +: LANE_DEFAULT] =
                    data[(LANES_DEFAULT-1-i)*LANE_DEFAULT +: LANE_DEFAULT];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/slice_swap_lane_rev.sv
// Combinational lane reversal: lane i of the result is lane (N-1-i) of the input when swap is set.
// Used on the capture path of slice_swap_skid (optional parity via SLICE_SWAP_PARITY_EN lives in the top).
module slice_swap_lane_rev #(
    parameter int WIDTH = 16,
    parameter int LANE  = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             swap,
    output logic [WIDTH-1:0] result
);

    localparam int N = WIDTH / LANE;

    logic [WIDTH-1:0] reversed;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign reversed[i*LANE +: LANE] = data[(N-1-i)*LANE +: LANE];
    end

    assign result = swap ? reversed : data;

endmodule

// File: rtl/slice_swap_skid.sv
// Ready/valid register slice with per-word lane reversal, 2-entry skid storage and delivery counter.
// Define SLICE_SWAP_PARITY_EN to add per-lane parity stored alongside each captured word.
module slice_swap_skid
    import slice_swap_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = LANE_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    ASYNCRESETn,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    swap_en,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             word_count
`ifdef SLICE_SWAP_PARITY_EN
    ,
    output logic [WIDTH/LANE-1:0]   out_parity
`endif
);

    localparam int N = WIDTH / LANE;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] cap_data;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [15:0]      count_q;
    logic             accept;
    logic             deliver;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;

    slice_swap_lane_rev #(
        .WIDTH (WIDTH),
        .LANE  (LANE)
    ) u_lane_rev (
        .data   (in_data),
        .swap   (swap_en),
        .result (cap_data)
    );

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid_q & out_ready;

    // Next-state and storage steering; accept cannot occur in FULL because in_ready is low there.
    always_comb begin
        next_state     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (deliver && !accept) begin
                    next_state = EMPTY;
                end else if (accept && deliver) begin
                    load_head_in = 1'b1;
                end
            end
            FULL: begin
                if (deliver) begin
                    next_state     = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Handshake flags are registered from next_state so neither depends combinationally on out_ready.
    always_ff @(posedge CLK or negedge ASYNCRESETn) begin
        if (!ASYNCRESETn) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != FULL);
            out_valid_q <= (next_state != EMPTY);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETn) begin
        if (!ASYNCRESETn) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in) begin
                head_q <= cap_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= cap_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETn) begin
        if (!ASYNCRESETn) begin
            count_q <= 16'h0000;
        end else if (deliver) begin
            count_q <= count_q + 16'h0001;
        end
    end

`ifdef SLICE_SWAP_PARITY_EN
    // Parity is taken after the swap so it always matches the lanes as presented on out_data.
    logic [N-1:0] cap_parity;
    logic [N-1:0] head_par_q;
    logic [N-1:0] skid_par_q;

    for (genvar i = 0; i < N; i++) begin : g_parity
        assign cap_parity[i] = ^cap_data[i*LANE +: LANE];
    end

    always_ff @(posedge CLK or negedge ASYNCRESETn) begin
        if (!ASYNCRESETn) begin
            head_par_q <= '0;
            skid_par_q <= '0;
        end else begin
            if (load_head_in) begin
                head_par_q <= cap_parity;
            end else if (load_head_skid) begin
                head_par_q <= skid_par_q;
            end
            if (load_skid) begin
                skid_par_q <= cap_parity;
            end
        end
    end

    assign out_parity = head_par_q;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = head_q;
    assign word_count = count_q;

endmodule
